// File: rtl/controller_pio_pkg.sv
// Shared PIO definitions: register word addresses and edge-capture modes.
// Used by the controller status input port and its output-PIO siblings.
package controller_pio_pkg;

  localparam logic [2:0] PIO_ADDR_DATA    = 3'd0;
  localparam logic [2:0] PIO_ADDR_IRQMASK = 3'd2;
  localparam logic [2:0] PIO_ADDR_EDGECAP = 3'd3;
  localparam logic [2:0] PIO_ADDR_SET     = 3'd4;
  localparam logic [2:0] PIO_ADDR_CLR     = 3'd5;

  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

  function automatic logic edge_hit(
    input int   edge_type,
    input logic rise,
    input logic fall
  );
    if (edge_type == EDGE_RISE)
      return rise;
    else if (edge_type == EDGE_FALL)
      return fall;
    else
      return rise | fall;
  endfunction

endpackage

// File: rtl/controller_pio_debounce.sv
// One status bit: 2-flop synchronizer, persistence counter, debounced level.
// Update events are combinational pulses coincident with the deb change.
module controller_pio_debounce #(
  parameter int DEBOUNCE_CYCLES = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic deb,
  output logic rise_evt,
  output logic fall_evt
);

  localparam logic [15:0] LP_DEB = 16'(DEBOUNCE_CYCLES);

  logic        r_s1;
  logic        r_s2;
  logic        r_deb;
  logic [15:0] r_cnt;
  logic        w_hit;

  assign w_hit = (r_s2 != r_deb) && (r_cnt == LP_DEB);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1  <= 1'b0;
      r_s2  <= 1'b0;
      r_deb <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_s1 <= din;
      r_s2 <= r_s1;
      if (r_s2 == r_deb) begin
        r_cnt <= '0;
      end else if (w_hit) begin
        r_deb <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  assign deb      = r_deb;
  assign rise_evt = w_hit & r_s2;
  assign fall_evt = w_hit & ~r_s2;

endmodule

// File: rtl/controller_tc_status.sv
// Avalon-MM status input port: debounced inputs, W1C edge capture,
// maskable level interrupt, zero-wait-state read mux.
import controller_pio_pkg::*;

module controller_tc_status #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 15,
  parameter int EDGE_TYPE       = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] w_deb;
  logic [WIDTH-1:0] w_rise;
  logic [WIDTH-1:0] w_fall;
  logic [WIDTH-1:0] w_set;
  logic [WIDTH-1:0] w_clr;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_cap;
  logic             w_wr;
  logic             w_wr_mask;
  logic             w_wr_cap;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    controller_pio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk      (clk),
      .reset_n  (reset_n),
      .din      (in_port[i]),
      .deb      (w_deb[i]),
      .rise_evt (w_rise[i]),
      .fall_evt (w_fall[i])
    );
    assign w_set[i] = edge_hit(EDGE_TYPE, w_rise[i], w_fall[i]);
  end

  if (WIDTH < 32) begin : g_unused
    logic w_unused_wdata;
    assign w_unused_wdata = ^writedata[31:WIDTH];
  end

  assign w_wr      = chipselect && !write_n;
  assign w_wr_mask = w_wr && (address == PIO_ADDR_IRQMASK);
  assign w_wr_cap  = w_wr && (address == PIO_ADDR_EDGECAP);
  assign w_clr     = w_wr_cap ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask <= '0;
      r_cap  <= '0;
    end else begin
      if (w_wr_mask)
        r_mask <= writedata[WIDTH-1:0];
      // a capture on the same edge as its clear keeps the bit set
      r_cap <= (r_cap & ~w_clr) | w_set;
    end
  end

  always_comb begin
    readdata = '0;
    unique case (1'b1)
      (address == PIO_ADDR_DATA):    readdata[WIDTH-1:0] = w_deb;
      (address == PIO_ADDR_IRQMASK): readdata[WIDTH-1:0] = r_mask;
      (address == PIO_ADDR_EDGECAP): readdata[WIDTH-1:0] = r_cap;
      default: ;
    endcase
  end

  assign irq = |(r_cap & r_mask);

endmodule

// File: tb/tb_controller_tc_status.sv
// Directed bench for controller_tc_status: register table plus
// hand-timed latency, glitch, W1C, collision and reset sequences.
module tb_controller_tc_status;

  logic        clk;
  logic        reset_n;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_port;
  logic [31:0] readdata;
  logic        irq;

  int n_total;
  int n_pass;

  controller_tc_status #(
    .WIDTH(4),
    .DEBOUNCE_CYCLES(15),
    .EDGE_TYPE(2)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_port),
    .readdata   (readdata),
    .irq        (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [2:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  raddr;
    logic [31:0] exp;
    logic        exp_irq;
  } vec_t;

  vec_t vt[11];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp)
      n_pass++;
    else
      $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic rd(input logic [2:0] a, output logic [31:0] d);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    #1;
    d = readdata;
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    write_n    = 1'b1;
    chipselect = 1'b0;
  endtask

  logic [31:0] d;

  initial begin
    n_total    = 0;
    n_pass     = 0;
    reset_n    = 1'b0;
    address    = 3'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_port    = 4'b0000;

    vt[0]  = '{1'b0, 3'd0, 32'h0,        3'd0, 32'h0, 1'b0};
    vt[1]  = '{1'b0, 3'd0, 32'h0,        3'd2, 32'h0, 1'b0};
    vt[2]  = '{1'b0, 3'd0, 32'h0,        3'd3, 32'h0, 1'b0};
    vt[3]  = '{1'b1, 3'd2, 32'hFFFFFFFF, 3'd2, 32'hF, 1'b0};
    vt[4]  = '{1'b1, 3'd0, 32'hF,        3'd0, 32'h0, 1'b0};
    vt[5]  = '{1'b1, 3'd1, 32'hF,        3'd1, 32'h0, 1'b0};
    vt[6]  = '{1'b1, 3'd6, 32'hF,        3'd6, 32'h0, 1'b0};
    vt[7]  = '{1'b1, 3'd3, 32'hF,        3'd3, 32'h0, 1'b0};
    vt[8]  = '{1'b1, 3'd2, 32'h3,        3'd2, 32'h3, 1'b0};
    vt[9]  = '{1'b0, 3'd0, 32'h0,        3'd4, 32'h0, 1'b0};
    vt[10] = '{1'b0, 3'd0, 32'h0,        3'd7, 32'h0, 1'b0};

    tick(3);
    chk("irq_in_reset", {31'd0, irq}, 32'd0);
    reset_n = 1'b1;
    tick(2);

    for (int i = 0; i < 11; i++) begin
      if (vt[i].we)
        wr(vt[i].waddr, vt[i].wdata);
      rd(vt[i].raddr, d);
      chk($sformatf("vec%0d_rd", i), d, vt[i].exp);
      chk($sformatf("vec%0d_irq", i), {31'd0, irq}, {31'd0, vt[i].exp_irq});
    end

    // latency: new level sampled at edge 1, accepted at edge 18
    wr(3'd2, 32'hF);
    in_port = 4'b0001;
    for (int k = 1; k <= 18; k++) begin
      tick(1);
      rd(3'd0, d);
      chk($sformatf("lat_data_e%0d", k), d, (k >= 18) ? 32'h1 : 32'h0);
      chk($sformatf("lat_irq_e%0d", k), {31'd0, irq},
          (k >= 18) ? 32'd1 : 32'd0);
    end
    rd(3'd3, d);
    chk("lat_cap", d, 32'h1);
    wr(3'd3, 32'h1);
    rd(3'd3, d);
    chk("lat_cap_clr", d, 32'h0);
    chk("lat_irq_clr", {31'd0, irq}, 32'd0);

    // glitch: 15 cycles of mismatch is rejected
    in_port = 4'b0101;
    tick(15);
    in_port = 4'b0001;
    tick(25);
    rd(3'd0, d);
    chk("glitch_data", d, 32'h1);
    rd(3'd3, d);
    chk("glitch_cap", d, 32'h0);
    chk("glitch_irq", {31'd0, irq}, 32'd0);

    // pulse: 16 cycles of mismatch is accepted
    in_port = 4'b0101;
    tick(16);
    in_port = 4'b0001;
    tick(1);
    rd(3'd0, d);
    chk("pulse_data_e17", d, 32'h1);
    tick(1);
    rd(3'd0, d);
    chk("pulse_data_e18", d, 32'h5);
    tick(15);
    rd(3'd0, d);
    chk("pulse_data_e33", d, 32'h5);
    tick(1);
    rd(3'd0, d);
    chk("pulse_data_e34", d, 32'h1);
    rd(3'd3, d);
    chk("pulse_cap", d, 32'h4);
    chk("pulse_irq", {31'd0, irq}, 32'd1);
    wr(3'd3, 32'hF);

    // W1C and mask interplay
    wr(3'd2, 32'h2);
    in_port = 4'b1011;
    tick(20);
    rd(3'd3, d);
    chk("w1c_cap_a", d, 32'hA);
    chk("w1c_irq_a", {31'd0, irq}, 32'd1);
    wr(3'd3, 32'h2);
    rd(3'd3, d);
    chk("w1c_cap_8", d, 32'h8);
    chk("w1c_irq_8", {31'd0, irq}, 32'd0);
    wr(3'd2, 32'h8);
    chk("mask_irq_8", {31'd0, irq}, 32'd1);
    wr(3'd3, 32'hF);
    chk("mask_irq_clr", {31'd0, irq}, 32'd0);

    // collision: W1C of bit 0 on its own fall-event edge
    in_port = 4'b1010;
    tick(17);
    wr(3'd3, 32'h1);
    rd(3'd0, d);
    chk("coll_data", d, 32'hA);
    rd(3'd3, d);
    chk("coll_cap", d, 32'h1);
    wr(3'd3, 32'h1);
    rd(3'd3, d);
    chk("coll_cap_clr", d, 32'h0);

    // async reset with bit 0 mid-debounce (cnt = 10)
    in_port = 4'b1011;
    tick(12);
    reset_n = 1'b0;
    in_port = 4'b0000;
    rd(3'd0, d);
    chk("rst_data", d, 32'h0);
    rd(3'd2, d);
    chk("rst_mask", d, 32'h0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    tick(2);
    reset_n = 1'b1;
    wr(3'd2, 32'hF);
    tick(30);
    rd(3'd0, d);
    chk("rst_data_after", d, 32'h0);
    rd(3'd3, d);
    chk("rst_cap_after", d, 32'h0);
    chk("rst_irq_after", {31'd0, irq}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
